// File: rtl/long_mul_pkg.sv
// Shared definitions for the long-multiply sequencer: FSM state encoding and
// default operand geometry.
package long_mul_pkg;
  localparam int LM_WIDTH = 32;
  localparam int LM_BPC   = 4;
  localparam int STEPS    = LM_WIDTH / LM_BPC;
  localparam int CNT_W    = $clog2(STEPS + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    FIX  = 3'd2,
    WLO  = 3'd3,
    WHI  = 3'd4
  } state_t;
endpackage

// File: rtl/long_mul_sequencer_if.sv
// Decoder/register-file side of the long-multiply sequencer. The core drives
// the master modport; the sequencer uses the slave modport.
interface long_mul_sequencer_if
  import long_mul_pkg::*;
#(
  parameter int WIDTH = LM_WIDTH
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       RdLo;
  logic [3:0]       RdHi;
  logic             Stall;
  logic             RegWrite;
  logic [3:0]       WA3;
  logic [WIDTH-1:0] WD3;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Signed, SrcA, SrcB, RdLo, RdHi,
    input  Stall, RegWrite, WA3, WD3, Busy, Done
  );

  modport slave (
    input  Start, Signed, SrcA, SrcB, RdLo, RdHi,
    output Stall, RegWrite, WA3, WD3, Busy, Done
  );
endinterface

// File: rtl/mul_step.sv
// One shift-add step: multiplicand times a BITS_PER_CYCLE-bit multiplier digit,
// aligned at digit position i_pos and added into the double-width accumulator.
module mul_step
  import long_mul_pkg::*;
#(
  parameter int WIDTH          = LM_WIDTH,
  parameter int BITS_PER_CYCLE = LM_BPC,
  parameter int POS_W          = CNT_W
) (
  input  logic [WIDTH-1:0]          i_mcand,
  input  logic [BITS_PER_CYCLE-1:0] i_digit,
  input  logic [POS_W-1:0]          i_pos,
  input  logic [2*WIDTH-1:0]        i_acc,
  output logic [2*WIDTH-1:0]        o_acc
);
  logic [2*WIDTH-1:0] w_mcand_x;
  logic [2*WIDTH-1:0] w_digit_x;
  logic [2*WIDTH-1:0] w_pp;

  assign w_mcand_x = {{WIDTH{1'b0}}, i_mcand};
  assign w_digit_x = {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, i_digit};
  assign w_pp      = (w_mcand_x * w_digit_x) << (i_pos * BITS_PER_CYCLE);
  assign o_acc     = i_acc + w_pp;
endmodule

// File: rtl/long_mul_sequencer.sv
// Iterative UMULL/SMULL engine: multiplies operand magnitudes by shift-add,
// fixes the sign, then writes RdLo and RdHi over the single write port.
module long_mul_sequencer
  import long_mul_pkg::*;
#(
  parameter int WIDTH          = LM_WIDTH,
  parameter int BITS_PER_CYCLE = LM_BPC
) (
  input logic                 clk,
  input logic                 reset,
  long_mul_sequencer_if.slave bus
);
  localparam int NSTEP  = WIDTH / BITS_PER_CYCLE;
  localparam int NCNT_W = $clog2(NSTEP + 1);
  localparam logic [NCNT_W-1:0] CNT_LOAD = NCNT_W'(NSTEP);
  localparam logic [NCNT_W-1:0] CNT_LAST = NCNT_W'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NCNT_W-1:0]    r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_neg;
  logic [3:0]           r_rd_lo;
  logic [3:0]           r_rd_hi;
  logic [NCNT_W-1:0]    w_pos;

  // The most negative operand maps onto itself, which is exactly 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic sgn, input logic [WIDTH-1:0] x);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic neg, input logic [2*WIDTH-1:0] m);
    return neg ? (~m + 1'b1) : m;
  endfunction

  assign w_pos = CNT_LOAD - r_cnt;

  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .POS_W          (NCNT_W)
  ) u_step (
    .i_mcand (r_mcand),
    .i_digit (r_mplier[BITS_PER_CYCLE-1:0]),
    .i_pos   (w_pos),
    .i_acc   (r_acc),
    .o_acc   (w_acc_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (bus.Start) begin
          r_mcand  <= magnitude(bus.Signed, bus.SrcA);
          r_mplier <= magnitude(bus.Signed, bus.SrcB);
          r_neg    <= bus.Signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
          r_rd_lo  <= bus.RdLo;
          r_rd_hi  <= bus.RdHi;
          r_acc    <= '0;
          r_cnt    <= CNT_LOAD;
        end
        MUL: begin
          r_acc    <= w_acc_step;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_cnt    <= r_cnt - 1'b1;
        end
        FIX:     r_acc <= apply_sign(r_neg, r_acc);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.Start) w_state_nxt = MUL;
      MUL:     if (r_cnt == CNT_LAST) w_state_nxt = FIX;
      FIX:     w_state_nxt = WLO;
      WLO:     w_state_nxt = WHI;
      WHI:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Write port only carries data in WLO/WHI; Stall drops in WHI so the core retires then.
  always_comb begin
    bus.Stall    = 1'b0;
    bus.RegWrite = 1'b0;
    bus.WA3      = 4'd0;
    bus.WD3      = '0;
    bus.Done     = 1'b0;
    bus.Busy     = (r_state != IDLE);
    case (r_state)
      IDLE: bus.Stall = bus.Start & ~reset;
      MUL,
      FIX:  bus.Stall = 1'b1;
      WLO: begin
        bus.Stall    = 1'b1;
        bus.RegWrite = 1'b1;
        bus.WA3      = r_rd_lo;
        bus.WD3      = r_acc[WIDTH-1:0];
      end
      WHI: begin
        bus.RegWrite = 1'b1;
        bus.WA3      = r_rd_hi;
        bus.WD3      = r_acc[2*WIDTH-1:WIDTH];
        bus.Done     = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_long_mul_sequencer.sv
// Randomised and directed bench for long_mul_sequencer against a plain-arithmetic
// product model and a modelled register file.
module tb_long_mul_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  logic [31:0] rf[16];
  logic [31:0] exp_rf[16];

  always #5 clk = ~clk;

  long_mul_sequencer_if #(.WIDTH(32)) bus ();

  long_mul_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sgn) return 64'(sa * sb);
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] lo, input logic [3:0] hi, input bit restart);
    logic [63:0] prod;
    logic [3:0]  ea;
    logic [31:0] ed;
    int          dones;
    prod  = model(sgn, a, b);
    dones = 0;
    exp_rf[lo] = prod[31:0];
    exp_rf[hi] = prod[63:32];
    bus.Start = 1'b1; bus.Signed = sgn; bus.SrcA = a; bus.SrcB = b;
    bus.RdLo = lo; bus.RdHi = hi;
    #1;
    chk("c0 stall", 64'(bus.Stall), 64'd1);
    chk("c0 busy", 64'(bus.Busy), 64'd0);
    tick();
    for (int c = 1; c <= 11; c++) begin
      if (c == 1) bus.Start = 1'b0;
      if (restart && c == 5) begin
        bus.Start = 1'b1; bus.SrcA = $urandom; bus.RdLo = 4'(c); bus.RdHi = 4'(c);
      end
      if (restart && c == 6) bus.Start = 1'b0;
      #1;
      ea = (c == 10) ? lo : (c == 11) ? hi : 4'd0;
      ed = (c == 10) ? prod[31:0] : (c == 11) ? prod[63:32] : 32'd0;
      chk($sformatf("c%0d stall", c), 64'(bus.Stall), 64'(c <= 10));
      chk($sformatf("c%0d busy", c), 64'(bus.Busy), 64'd1);
      chk($sformatf("c%0d regwrite", c), 64'(bus.RegWrite), 64'(c >= 10));
      chk($sformatf("c%0d wa3", c), 64'(bus.WA3), 64'(ea));
      chk($sformatf("c%0d wd3", c), 64'(bus.WD3), 64'(ed));
      if (bus.RegWrite) rf[bus.WA3] = bus.WD3;
      if (bus.Done) dones++;
      tick();
    end
    chk("c12 busy", 64'(bus.Busy), 64'd0);
    chk("c12 stall", 64'(bus.Stall), 64'd0);
    chk("c12 regwrite", 64'(bus.RegWrite), 64'd0);
    chk("done pulses", 64'(dones), 64'd1);
    chk("rf lo", 64'(rf[lo]), 64'(exp_rf[lo]));
    chk("rf hi", 64'(rf[hi]), 64'(exp_rf[hi]));
  endtask

  initial begin
    logic [31:0] a, b;
    bit          sgn;
    for (int i = 0; i < 16; i++) begin rf[i] = '0; exp_rf[i] = '0; end
    bus.Start = 1'b0; bus.Signed = 1'b0; bus.SrcA = '0; bus.SrcB = '0;
    bus.RdLo = '0; bus.RdHi = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst stall", 64'(bus.Stall), 64'd0);
    chk("rst busy", 64'(bus.Busy), 64'd0);
    chk("rst regwrite", 64'(bus.RegWrite), 64'd0);
    chk("rst done", 64'(bus.Done), 64'd0);
    chk("rst wa3", 64'(bus.WA3), 64'd0);
    chk("rst wd3", 64'(bus.WD3), 64'd0);
    chk("rst count", 64'(dut.r_cnt), 64'd0);
    chk("rst acc", dut.r_acc, 64'd0);

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 4'd3, 1'b0);
    chk("umull max lo", 64'(rf[2]), 64'h0000_0001);
    chk("umull max hi", 64'(rf[3]), 64'hFFFF_FFFE);

    run_op(1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 4'd4, 4'd6, 1'b1);
    chk("smull -2*3 lo", 64'(rf[4]), 64'hFFFF_FFFA);
    chk("smull -2*3 hi", 64'(rf[6]), 64'hFFFF_FFFF);

    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 4'd7, 4'd8, 1'b0);
    chk("smull min lo", 64'(rf[7]), 64'h0000_0000);
    chk("smull min hi", 64'(rf[8]), 64'h4000_0000);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 4'd9, 4'd10, 1'b0);
    chk("umull min hi", 64'(rf[10]), 64'h4000_0000);

    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 4'd5, 4'd5, 1'b0);
    chk("same rd r5", 64'(rf[5]), 64'h0000_0001);

    // Abort in MUL at cycle 4
    bus.Start = 1'b1; bus.Signed = 1'b0; bus.SrcA = 32'h1234_5678; bus.SrcB = 32'h9ABC_DEF0;
    bus.RdLo = 4'd11; bus.RdHi = 4'd12;
    tick();
    bus.Start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      #1;
      chk($sformatf("abort c%0d busy", c), 64'(bus.Busy), 64'd0);
      chk($sformatf("abort c%0d regwrite", c), 64'(bus.RegWrite), 64'd0);
      tick();
    end
    run_op(1'b0, 32'd7, 32'd6, 4'd11, 4'd12, 1'b0);
    chk("7*6 lo", 64'(rf[11]), 64'd42);
    chk("7*6 hi", 64'(rf[12]), 64'd0);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'd0;
        default: a = $urandom;
      endcase
      b   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      sgn = 1'($urandom_range(0, 1));
      run_op(sgn, a, b, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
